// File: rtl/spi_image_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_image_loader_pkg
// Description : Shared types and constants for the SPI image loader:
//               loader FSM state encoding, header length and the depth of
//               the SPI input synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_image_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PIXELS  = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

    localparam int HEADER_BYTES    = 4;
    localparam int SPI_SYNC_STAGES = 2;

endpackage : spi_image_loader_pkg
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_rx
// Description : SPI mode-0 (MSB first) byte receiver, oversampled in the
//               system clock domain. Synchronizes SCLK/MOSI/CS, detects
//               SCLK edges, assembles bytes and echoes the previously
//               received byte on MISO.
// Revision    : 1.0 - initial release
// Ports       :
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_spi_clk    in   raw SPI clock (idle low)
//   i_spi_mosi   in   raw SPI data in
//   i_spi_cs     in   raw chip select, active low
//   i_clear      in   starts a new session: loopback data returns to 0x00
//   o_spi_miso   out  loopback data, changes on synchronized SCLK falls
//   o_byte_valid out  one-cycle strobe when a full byte has been received
//   o_rx_byte    out  last completed byte
// ============================================================================
module spi_byte_rx
    import spi_image_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_spi_clk,
    input  logic       i_spi_mosi,
    input  logic       i_spi_cs,
    input  logic       i_clear,
    output logic       o_spi_miso,
    output logic       o_byte_valid,
    output logic [7:0] o_rx_byte
);

    logic [SPI_SYNC_STAGES-1:0] r_clk_sync;
    logic [SPI_SYNC_STAGES-1:0] r_mosi_sync;
    logic [SPI_SYNC_STAGES-1:0] r_cs_sync;
    logic                       r_clk_prev;
    logic [2:0]                 r_bit_cnt;
    logic [7:0]                 r_rx_shift;
    logic [7:0]                 r_rx_byte;
    logic [7:0]                 r_tx_shift;
    logic                       r_miso;
    logic                       r_byte_valid;

    logic       w_sclk;
    logic       w_mosi;
    logic       w_cs_n;
    logic       w_rise;
    logic       w_fall;
    logic       w_last_bit;
    logic [7:0] w_rx_next;

    assign w_sclk     = r_clk_sync[SPI_SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SPI_SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SPI_SYNC_STAGES-1];
    assign w_rise     = w_sclk & ~r_clk_prev;
    assign w_fall     = ~w_sclk & r_clk_prev;
    assign w_rx_next  = {r_rx_shift[6:0], w_mosi};
    assign w_last_bit = ~w_cs_n & w_rise & (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync   <= '0;
            r_mosi_sync  <= '0;
            r_cs_sync    <= '1;   // deselected until the pin is sampled
            r_clk_prev   <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_rx_byte    <= 8'h00;
            r_tx_shift   <= 8'h00;
            r_miso       <= 1'b0;
            r_byte_valid <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[SPI_SYNC_STAGES-2:0], i_spi_clk};
            r_mosi_sync  <= {r_mosi_sync[SPI_SYNC_STAGES-2:0], i_spi_mosi};
            r_cs_sync    <= {r_cs_sync[SPI_SYNC_STAGES-2:0], i_spi_cs};
            r_clk_prev   <= w_sclk;
            r_byte_valid <= 1'b0;

            // Deselect drops any partially shifted bits; the counter
            // wraps to zero by itself after the eighth bit.
            if (w_cs_n) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_rx_byte    <= w_rx_next;
                end
            end

            // The completed byte is loaded for echo; its MSB appears on
            // the falling edge that follows the eighth rising edge, ahead
            // of the first sample of the next byte.
            if (i_clear) begin
                r_tx_shift <= 8'h00;
                r_miso     <= 1'b0;
            end else if (w_last_bit) begin
                r_tx_shift <= w_rx_next;
            end else if (!w_cs_n && w_fall) begin
                r_miso     <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    assign o_spi_miso   = r_miso;
    assign o_byte_valid = r_byte_valid;
    assign o_rx_byte    = r_rx_byte;

endmodule : spi_byte_rx
`default_nettype wire

// File: rtl/spi_image_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_image_loader
// Description : Receives one grayscale image over SPI, parses the 4-byte
//               size header (w_hi, w_lo, h_hi, h_lo) and streams pixel
//               bytes into the image SRAM write port in raster order.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst_n             system clock, asynchronous active-low reset
//   SPI_CLK/MOSI/CS/MISO   SPI slave pins (mode 0, CS active low)
//   start                  one-cycle pulse arming a new image load
//   request_flag           high while awaiting or accepting a frame
//   wr_en/wr_addr/wr_data  SRAM write port, one strobe per pixel
//   true_w_out/true_h_out  received image width / height
//   done                   level, last pixel written, cleared by start
//   err                    level, header out of range, cleared by start
// ============================================================================
module spi_image_loader
    import spi_image_loader_pkg::*;
#(
    parameter int IMAGEX           = 256,
    parameter int IMAGEY           = 256,
    parameter int IMAGE_ADDR_WIDTH = 16,
    parameter int RGB_SIZE         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        SPI_CLK,
    input  logic                        SPI_MOSI,
    input  logic                        SPI_CS,
    output logic                        SPI_MISO,
    input  logic                        start,
    output logic                        request_flag,
    output logic                        wr_en,
    output logic [IMAGE_ADDR_WIDTH-1:0] wr_addr,
    output logic [RGB_SIZE-1:0]         wr_data,
    output logic [8:0]                  true_w_out,
    output logic [8:0]                  true_h_out,
    output logic                        done,
    output logic                        err
);

    localparam logic [8:0] c_MAX_W = 9'(IMAGEX);
    localparam logic [8:0] c_MAX_H = 9'(IMAGEY);
    localparam logic [1:0] c_LAST_HDR = 2'(HEADER_BYTES - 1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] c_ADDR_ONE =
        {{(IMAGE_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IMAGE_ADDR_WIDTH:0] c_REM_ONE =
        {{IMAGE_ADDR_WIDTH{1'b0}}, 1'b1};

    logic       w_byte_valid;
    logic [7:0] w_rx_byte;

    spi_byte_rx u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_spi_clk    (SPI_CLK),
        .i_spi_mosi   (SPI_MOSI),
        .i_spi_cs     (SPI_CS),
        .i_clear      (start),
        .o_spi_miso   (SPI_MISO),
        .o_byte_valid (w_byte_valid),
        .o_rx_byte    (w_rx_byte)
    );

    loader_state_t               r_state,     w_state_nxt;
    logic [1:0]                  r_hdr_cnt,   w_hdr_cnt_nxt;
    logic                        r_w_hi,      w_w_hi_nxt;
    logic                        r_h_hi,      w_h_hi_nxt;
    logic [8:0]                  r_w,         w_w_nxt;
    logic [8:0]                  r_h,         w_h_nxt;
    logic [IMAGE_ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
    logic [IMAGE_ADDR_WIDTH:0]   r_remaining, w_remaining_nxt;
    logic                        r_wr_en,     w_wr_en_nxt;
    logic [IMAGE_ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic [RGB_SIZE-1:0]         r_wr_data,   w_wr_data_nxt;
    logic                        r_done,      w_done_nxt;
    logic                        r_err,       w_err_nxt;

    logic [8:0]  w_h_cand;
    logic [17:0] w_product;
    logic        w_hdr_bad;

    // Height candidate formed while its low byte is on the bus, so the
    // range check and pixel count are ready in the same cycle.
    assign w_h_cand  = {r_h_hi, w_rx_byte};
    assign w_product = {9'd0, r_w} * {9'd0, w_h_cand};
    assign w_hdr_bad = (r_w == 9'd0) || (w_h_cand == 9'd0) ||
                       (r_w > c_MAX_W) || (w_h_cand > c_MAX_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hdr_cnt   <= 2'd0;
            r_w_hi      <= 1'b0;
            r_h_hi      <= 1'b0;
            r_w         <= 9'd0;
            r_h         <= 9'd0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hdr_cnt   <= w_hdr_cnt_nxt;
            r_w_hi      <= w_w_hi_nxt;
            r_h_hi      <= w_h_hi_nxt;
            r_w         <= w_w_nxt;
            r_h         <= w_h_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hdr_cnt_nxt   = r_hdr_cnt;
        w_w_hi_nxt      = r_w_hi;
        w_h_hi_nxt      = r_h_hi;
        w_w_nxt         = r_w;
        w_h_nxt         = r_h;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        // Status levels trail the state by one cycle, so done rises the
        // cycle after the final write strobe.
        w_done_nxt      = (r_state == ST_DONE);
        w_err_nxt       = (r_state == ST_ERROR);

        if (start) begin
            // A start from any state re-arms; SRAM contents are untouched.
            w_state_nxt   = ST_REQUEST;
            w_hdr_cnt_nxt = 2'd0;
            w_w_hi_nxt    = 1'b0;
            w_h_hi_nxt    = 1'b0;
            w_w_nxt       = 9'd0;
            w_h_nxt       = 9'd0;
            w_done_nxt    = 1'b0;
            w_err_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_REQUEST: begin
                    if (w_byte_valid) begin
                        w_w_hi_nxt    = w_rx_byte[0];
                        w_hdr_cnt_nxt = 2'd1;
                        w_state_nxt   = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (w_byte_valid) begin
                        w_hdr_cnt_nxt = r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd1) begin
                            w_w_nxt = {r_w_hi, w_rx_byte};
                        end else if (r_hdr_cnt == 2'd2) begin
                            w_h_hi_nxt = w_rx_byte[0];
                        end else if (r_hdr_cnt == c_LAST_HDR) begin
                            w_h_nxt = w_h_cand;
                            if (w_hdr_bad) begin
                                w_state_nxt = ST_ERROR;
                            end else begin
                                w_state_nxt     = ST_PIXELS;
                                w_addr_nxt      = '0;
                                w_remaining_nxt = w_product[IMAGE_ADDR_WIDTH:0];
                            end
                        end
                    end
                end
                ST_PIXELS: begin
                    if (w_byte_valid) begin
                        w_wr_en_nxt     = 1'b1;
                        w_wr_addr_nxt   = r_addr;
                        w_wr_data_nxt   = RGB_SIZE'(w_rx_byte);
                        w_addr_nxt      = r_addr + c_ADDR_ONE;
                        w_remaining_nxt = r_remaining - c_REM_ONE;
                        if (r_remaining == c_REM_ONE) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign request_flag = (r_state == ST_REQUEST) || (r_state == ST_HEADER) ||
                          (r_state == ST_PIXELS);
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign true_w_out   = r_w;
    assign true_h_out   = r_h;
    assign done         = r_done;
    assign err          = r_err;

endmodule : spi_image_loader
`default_nettype wire
